// File: rtl/sopc_data_bus_pkg.sv
// sopc_bus_pkg: shared types and constants for the SOPC data-side bus.
//   state_e      - interconnect FSM states (IDLE/ERR/ACCESS/DONE)
//   ERR_DATA     - read data returned on decode error or timeout
//   ERR_CNT_W    - width of the saturating error counter
//   sat_inc()    - saturating increment for the error counter
package sopc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int ERR_DATA  = 0;
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sopc_data_bus_if.sv
// sopc_data_bus_if: CPU-side and slave-side signals of the data bus.
//   m_*  CPU data port: m_ce/m_we/m_sel/m_addr/m_wdata in, m_rdata/m_stall/m_ack/m_err out
//   s_*  slave ports:   s_ce (one-hot), s_we/s_sel/s_addr/s_wdata broadcast, s_rdata/s_ready back
// Modports:
//   slave  - the interconnect as seen by the CPU (it is the CPU's slave)
//   master - the interconnect as seen by the slaves (it is their master)
// Handshake: the CPU raises m_ce with a stable request; m_stall stays high
// until the completion cycle, in which m_ack pulses for exactly one cycle
// (with m_err on failure). A slave sees s_ce high for as long as the access
// lasts and finishes it by raising s_ready in any of those cycles.
interface sopc_data_bus_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic                         m_ce;
    logic                         m_we;
    logic [DATA_W/8-1:0]          m_sel;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_stall;
    logic                         m_ack;
    logic                         m_err;

    logic [NUM_SLAVES-1:0]        s_ce;
    logic                         s_we;
    logic [DATA_W/8-1:0]          s_sel;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ready;

    modport slave (
        input  m_ce, m_we, m_sel, m_addr, m_wdata,
        output m_rdata, m_stall, m_ack, m_err
    );

    modport master (
        output s_ce, s_we, s_sel, s_addr, s_wdata,
        input  s_rdata, s_ready
    );
endinterface

// File: rtl/sopc_data_bus_timeout.sv
// sopc_bus_timeout: access-duration counter.
//   clk, rst   - clock, asynchronous active-low reset
//   clr_i      - force the count back to 0 (has priority over en_i)
//   en_i       - advance the count by one
//   expire_o   - high while the count equals TIMEOUT-1
module sopc_bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    // TIMEOUT >= 2, so CW >= 1 and TIMEOUT-1 always fits.
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/sopc_data_bus.sv
// sopc_data_bus: CPU data port to NUM_SLAVES memory-mapped slaves.
//   clk, rst     - clock, asynchronous active-low reset
//   cpu          - CPU-side request/response (sopc_data_bus_if.slave)
//   mem          - slave-side select/broadcast/ready (sopc_data_bus_if.master)
//   err_cnt      - saturating count of transactions acked with m_err
//   state_dbg_o  - current FSM state
// The top address bits pick the slave. The request is latched in IDLE and
// broadcast from the latch, so dropping m_ce mid-transaction cannot tear a
// write. Accesses that never see s_ready are ended by the timeout.
module sopc_data_bus
    import sopc_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sopc_data_bus_if.slave        cpu,
    sopc_data_bus_if.master       mem,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output state_e                state_dbg_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam logic [IDX_W:0] NUM_SLAVES_W = (IDX_W + 1)'(NUM_SLAVES);

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0]       req_idx;
    logic                   req_in_range;
    logic                   sel_ready;
    logic [DATA_W-1:0]      sel_rdata;
    logic [NUM_SLAVES-1:0]  s_ce_vec;
    logic                   in_access;
    logic                   expire;

    assign req_idx      = cpu.m_addr[ADDR_W-1 -: IDX_W];
    assign req_in_range = ({1'b0, req_idx} < NUM_SLAVES_W);
    assign in_access    = (state_q == ACCESS);

    // Only the addressed slave's ready/data are looked at; the rest are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_ce_vec  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready   = mem.s_ready[i];
                sel_rdata   = mem.s_rdata[i*DATA_W +: DATA_W];
                s_ce_vec[i] = in_access;
            end
        end
    end

    sopc_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_access),
        .en_i     (in_access),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cpu.m_ce) begin
                    we_d    = cpu.m_we;
                    sel_d   = cpu.m_sel;
                    addr_d  = cpu.m_addr;
                    wdata_d = cpu.m_wdata;
                    idx_d   = req_idx;
                    rdata_d = DATA_W'(ERR_DATA);
                    err_d   = 1'b0;
                    state_d = req_in_range ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                // Ready wins over expiry when both land in the same cycle.
                if (sel_ready) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (expire) begin
                    rdata_d = DATA_W'(ERR_DATA);
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            ERR: begin
                rdata_d = DATA_W'(ERR_DATA);
                err_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (err_q) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mem.s_ce    = s_ce_vec;
    assign mem.s_we    = we_q;
    assign mem.s_sel   = sel_q;
    assign mem.s_addr  = addr_q;
    assign mem.s_wdata = wdata_q;

    assign cpu.m_ack   = (state_q == DONE);
    assign cpu.m_err   = (state_q == DONE) & err_q;
    assign cpu.m_rdata = (state_q == DONE) ? rdata_q : '0;
    // A request arriving in DONE stays stalled-free but is only taken in IDLE.
    assign cpu.m_stall = cpu.m_ce & (state_q != DONE);

    assign err_cnt     = err_cnt_q;
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_sopc_data_bus.sv
module tb_sopc_data_bus;
    import sopc_bus_pkg::*;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] err_cnt;
    state_e     state_dbg;

    sopc_data_bus_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus();

    sopc_data_bus #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .IDX_W      (IW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (bus),
        .mem         (bus),
        .err_cnt     (err_cnt),
        .state_dbg_o (state_dbg)
    );

    // ---------------- slave models ----------------
    // wait_cfg: cycles of s_ce before ready (0 = ready tied high, -1 = never).
    int            wait_cfg[NS];
    logic [DW-1:0] rdata_cfg[NS];
    logic [NS-1:0] spurious = '0;
    int            sel_cnt[NS] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) sel_cnt[i] <= bus.s_ce[i] ? sel_cnt[i] + 1 : 0;
    end

    always_comb begin
        bus.s_ready = '0;
        bus.s_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            bus.s_rdata[i*DW +: DW] = rdata_cfg[i];
            bus.s_ready[i] = spurious[i];
            if (wait_cfg[i] == 0) bus.s_ready[i] = 1'b1;
            else if (wait_cfg[i] > 0 && bus.s_ce[i] && sel_cnt[i] >= wait_cfg[i]) bus.s_ready[i] = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: each request becomes a timeline record.
    typedef struct {
        int          start;
        int          ack;
        bit          in_range;
        int          idx;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    txn_t txq[$];
    int   model_errcnt = 0;

    function automatic txn_t make_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int start);
        txn_t t;
        int   w;
        t.start = start; t.we = we; t.sel = sel; t.addr = addr; t.wdata = wdata;
        t.idx = int'(addr[31:28]);
        t.in_range = (t.idx < NS);
        if (!t.in_range) begin
            t.ack = start + 2; t.err = 1'b1; t.rdata = '0;
        end else begin
            w = wait_cfg[t.idx];
            if (w < 0 || w >= TO) begin
                t.ack = start + TO + 1; t.err = 1'b1; t.rdata = '0;
            end else begin
                t.ack = start + 2 + w; t.err = 1'b0; t.rdata = we ? 32'h0 : rdata_cfg[t.idx];
            end
        end
        return t;
    endfunction

    // Per-cycle compare of DUT outputs against the model timeline.
    always @(negedge clk) begin : cmp_proc
        logic [NS-1:0] e_sce;
        logic          e_ack;
        bit            act;
        txn_t          t;
        if (!rst) begin
            check("rst_s_ce",    64'(bus.s_ce),    64'(0));
            check("rst_s_we",    64'(bus.s_we),    64'(0));
            check("rst_s_sel",   64'(bus.s_sel),   64'(0));
            check("rst_s_addr",  64'(bus.s_addr),  64'(0));
            check("rst_s_wdata", 64'(bus.s_wdata), 64'(0));
            check("rst_m_rdata", 64'(bus.m_rdata), 64'(0));
            check("rst_m_ack",   64'(bus.m_ack),   64'(0));
            check("rst_m_err",   64'(bus.m_err),   64'(0));
            check("rst_err_cnt", 64'(err_cnt),     64'(0));
            check("rst_state",   64'(state_dbg),   64'(IDLE));
        end else begin
            e_sce = '0;
            e_ack = 1'b0;
            act   = 1'b0;
            if (txq.size() > 0) begin
                t = txq[0];
                act = (cyc > t.start) && (cyc <= t.ack);
                if (t.in_range && cyc > t.start && cyc < t.ack) e_sce[t.idx] = 1'b1;
                e_ack = (cyc == t.ack);
            end
            check("s_ce",    64'(bus.s_ce),    64'(e_sce));
            check("m_ack",   64'(bus.m_ack),   64'(e_ack));
            check("m_stall", 64'(bus.m_stall), 64'(bus.m_ce & ~e_ack));
            check("err_cnt", 64'(err_cnt),     64'(model_errcnt));
            if (act) begin
                check("s_we",    64'(bus.s_we),    64'(t.we));
                check("s_sel",   64'(bus.s_sel),   64'(t.sel));
                check("s_addr",  64'(bus.s_addr),  64'(t.addr));
                check("s_wdata", 64'(bus.s_wdata), 64'(t.wdata));
            end
            if (e_ack) begin
                check("m_err",   64'(bus.m_err),   64'(t.err));
                check("m_rdata", 64'(bus.m_rdata), 64'(t.rdata));
                if (t.err) model_errcnt = (model_errcnt == 255) ? 255 : model_errcnt + 1;
                void'(txq.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one request, waits (bounded) for its ack and checks the
    // hand-computed latency, data, error flag and number of s_ce cycles.
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit drop_ce, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_sce_n,
                          input string tag);
        int          start, lat, n, sce_n;
        bit          got;
        logic [31:0] rd;
        logic        er;
        @(posedge clk); #1;
        bus.m_ce = 1'b1; bus.m_we = we; bus.m_sel = sel; bus.m_addr = addr; bus.m_wdata = wdata;
        start = cyc;
        txq.push_back(make_txn(we, sel, addr, wdata, start));
        got = 1'b0; n = 0; sce_n = 0; lat = -1; rd = '0; er = 1'b0;
        while (!got && n < TO + 20) begin
            @(negedge clk);
            if (bus.s_ce != '0) sce_n++;
            if (bus.m_ack) begin
                got = 1'b1; lat = cyc - start; rd = bus.m_rdata; er = bus.m_err;
            end else begin
                @(posedge clk); #1;
                if (drop_ce) begin
                    bus.m_ce = 1'b0; bus.m_wdata = ~wdata; bus.m_sel = ~sel;
                end
            end
            n++;
        end
        check({tag, "_acked"}, 64'(got),   64'(1));
        check({tag, "_lat"},   64'(lat),   64'(exp_lat));
        check({tag, "_rdata"}, 64'(rd),    64'(exp_rd));
        check({tag, "_err"},   64'(er),    64'(exp_err));
        check({tag, "_sce_n"}, 64'(sce_n), 64'(exp_sce_n));
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        bus.m_ce = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rs_start;
        wait_cfg  = '{0, -1, 3, 2};
        rdata_cfg = '{32'h1234_5678, 32'hBBBB_1111, 32'hCCCC_2222, 32'hDDDD_3333};
        bus.m_ce = 1'b0; bus.m_we = 1'b0; bus.m_sel = '0; bus.m_addr = '0; bus.m_wdata = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // zero-wait read, slave 0
        do_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0, 2, 32'h1234_5678, 1'b0, 1, "rd_s0");
        // write with 3 wait states, slave 2
        do_txn(1'b1, 4'b0011, 32'h2000_0004, 32'hA5A5_5A5A, 1'b0, 5, 32'h0, 1'b0, 4, "wr_s2");
        // decode error
        do_txn(1'b0, 4'hF, 32'hF000_0000, 32'h0, 1'b0, 2, 32'h0, 1'b1, 0, "dec");
        idle(1);
        check("err_cnt_after_dec", 64'(err_cnt), 64'(1));
        // timeout on slave 1
        do_txn(1'b0, 4'hF, 32'h1000_0020, 32'h0, 1'b0, 17, 32'h0, 1'b1, 16, "tmo");
        idle(1);
        check("err_cnt_after_tmo", 64'(err_cnt), 64'(2));
        // m_ce dropped after the first cycle, write still completes from the latch
        do_txn(1'b1, 4'hF, 32'h3000_0008, 32'h0BAD_F00D, 1'b1, 4, 32'h0, 1'b0, 3, "drop");
        idle(1);
        // stray ready from slave 3 during a slave-1 access
        wait_cfg[1] = 4;
        spurious[3] = 1'b1;
        do_txn(1'b0, 4'hF, 32'h1000_0000, 32'h0, 1'b0, 6, 32'hBBBB_1111, 1'b0, 5, "spur");
        idle(1);
        spurious[3] = 1'b0;
        // back-to-back
        do_txn(1'b0, 4'hF, 32'h0000_0000, 32'h0, 1'b0, 2, 32'h1234_5678, 1'b0, 1, "b2b_a");
        do_txn(1'b0, 4'hF, 32'h3000_0000, 32'h0, 1'b0, 4, 32'hDDDD_3333, 1'b0, 3, "b2b_b");
        do_txn(1'b0, 4'hF, 32'h4000_0000, 32'h0, 1'b0, 2, 32'h0, 1'b1, 0, "b2b_c");
        idle(1);
        check("err_cnt_after_b2b", 64'(err_cnt), 64'(3));

        // reset in the second ACCESS cycle
        wait_cfg[1] = 5;
        @(posedge clk); #1;
        bus.m_ce = 1'b1; bus.m_we = 1'b0; bus.m_sel = 4'hF; bus.m_addr = 32'h1000_000C; bus.m_wdata = '0;
        rs_start = cyc;
        txq.push_back(make_txn(1'b0, 4'hF, 32'h1000_000C, 32'h0, rs_start));
        repeat (3) @(negedge clk);
        check("rst_pre_sce", 64'(bus.s_ce), 64'(4'b0010));
        #2;
        rst = 1'b0;
        bus.m_ce = 1'b0;
        txq.delete();
        model_errcnt = 0;
        #1;
        check("rst_async_sce", 64'(bus.s_ce), 64'(0));
        check("rst_no_ack",    64'(bus.m_ack), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        // normal request after reset
        wait_cfg[1] = 1;
        do_txn(1'b0, 4'hF, 32'h1000_0004, 32'h0, 1'b0, 3, 32'hBBBB_1111, 1'b0, 2, "post_rst");
        idle(1);
        check("err_cnt_post_rst", 64'(err_cnt), 64'(0));

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            do_txn(1'b0, 4'hF, 32'h8000_0000 + 32'(i * 4), 32'h0, 1'b0, 2, 32'h0, 1'b1, 0, "sat");
        end
        idle(2);
        check("err_cnt_sat", 64'(err_cnt), 64'(255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
